loadable_down_counter_dec_60: RTL and testbench

//  Two-digit BCD modulo-60 down counter (59..00) for the seconds or minutes field of a timer.
//  It decrements once per qualified tick on clk_time and can be preset from a user value.
//  On wrap 00->59 it emits dec_clk, a one-cycle borrow pulse that drives the next-higher

---
 rtl/loadable_down_counter_dec_60_pkg.sv | 17 +
 rtl/loadable_down_counter_dec_60_bcd_down_digit.sv | 39 +++
 rtl/loadable_down_counter_dec_60.sv | 73 +++++++
 tb/tb_loadable_down_counter_dec_60.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/loadable_down_counter_dec_60_pkg.sv
// Shared constants and helpers for the two-digit BCD modulo-60 down counter.
// Digit limits live here so the top and the digit cells agree on widths.
package loadable_down_counter_dec_60_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t ONES_MAX_DEF = 4'd9;
  localparam bcd_digit_t TENS_MAX_DEF = 4'd5;

  // Saturate a user preset so an out-of-range digit can never enter the counter.
  function automatic bcd_digit_t clamp_digit(input bcd_digit_t val, input bcd_digit_t max_val);
    clamp_digit = (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/loadable_down_counter_dec_60_bcd_down_digit.sv
// One loadable BCD down-counting digit that wraps from 0 to max_val.
// borrow flags that this digit is at 0 and is being decremented this cycle.
module bcd_down_digit
  import loadable_down_counter_dec_60_pkg::*;
(
  input  logic               clk,
  input  logic               reset_p,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec_en,
  input  logic [DIGIT_W-1:0] max_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow
);

  logic [DIGIT_W-1:0] digit_d;
  logic [DIGIT_W-1:0] digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec_en) begin
      digit_d = (digit_q == '0) ? max_val : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign borrow = dec_en & (digit_q == '0);

endmodule

// File: rtl/loadable_down_counter_dec_60.sv
// Two-digit BCD modulo-60 down counter with clamped preset and a one-cycle
// borrow pulse (dec_clk) on every 00 -> 59 wrap.
module loadable_down_counter_dec_60
  import loadable_down_counter_dec_60_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] ONES_MAX = ONES_MAX_DEF,
  parameter logic [DIGIT_W-1:0] TENS_MAX = TENS_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset_p,
  input  logic               clk_time,
  input  logic               load_enable,
  input  logic [DIGIT_W-1:0] set_value1,
  input  logic [DIGIT_W-1:0] set_value10,
  output logic [DIGIT_W-1:0] dec1,
  output logic [DIGIT_W-1:0] dec10,
  output logic               dec_clk
);

  logic [DIGIT_W-1:0] ones_load_val;
  logic [DIGIT_W-1:0] tens_load_val;
  logic               ones_dec_en;
  logic               ones_borrow;
  logic               tens_borrow;
  logic               dec_clk_d;
  logic               dec_clk_q;

  always_comb begin
    ones_load_val = clamp_digit(set_value1, ONES_MAX);
    tens_load_val = clamp_digit(set_value10, TENS_MAX);
  end

  // Load wins over a coincident tick, so the tick is masked before it reaches
  // the digit chain; that also keeps dec_clk low on a load cycle.
  assign ones_dec_en = clk_time & ~load_enable;

  bcd_down_digit u_ones (
    .clk      (clk),
    .reset_p  (reset_p),
    .load     (load_enable),
    .load_val (ones_load_val),
    .dec_en   (ones_dec_en),
    .max_val  (ONES_MAX),
    .digit    (dec1),
    .borrow   (ones_borrow)
  );

  bcd_down_digit u_tens (
    .clk      (clk),
    .reset_p  (reset_p),
    .load     (load_enable),
    .load_val (tens_load_val),
    .dec_en   (ones_borrow),
    .max_val  (TENS_MAX),
    .digit    (dec10),
    .borrow   (tens_borrow)
  );

  always_comb begin
    dec_clk_d = tens_borrow;
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      dec_clk_q <= 1'b0;
    end else begin
      dec_clk_q <= dec_clk_d;
    end
  end

  assign dec_clk = dec_clk_q;

endmodule

// File: tb/tb_loadable_down_counter_dec_60.sv
// Directed bench for the BCD modulo-60 down counter: reset, load/clamp,
// single ticks, the 00 -> 59 wrap pulse and reset priority.
module tb_loadable_down_counter_dec_60;

  logic       clk;
  logic       reset_p;
  logic       clk_time;
  logic       load_enable;
  logic [3:0] set_value1;
  logic [3:0] set_value10;
  logic [3:0] dec1;
  logic [3:0] dec10;
  logic       dec_clk;

  int vec_cnt;
  int err_cnt;
  int pulse_cnt;

  loadable_down_counter_dec_60 dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .clk_time    (clk_time),
    .load_enable (load_enable),
    .set_value1  (set_value1),
    .set_value10 (set_value10),
    .dec1        (dec1),
    .dec10       (dec10),
    .dec_clk     (dec_clk)
  );

  // clock / reset block: 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one clock cycle, then sample #1 after the edge and release inputs.
  task automatic cycle(input logic rst, input logic ld, input logic tk,
                       input logic [3:0] tens, input logic [3:0] ones);
    reset_p     = rst;
    load_enable = ld;
    clk_time    = tk;
    set_value10 = tens;
    set_value1  = ones;
    @(posedge clk);
    #1;
    reset_p     = 1'b0;
    load_enable = 1'b0;
    clk_time    = 1'b0;
    if (dec_clk === 1'b1) pulse_cnt++;
  endtask

  task automatic expect_cnt(input string tag, input logic [7:0] bcd, input logic pulse);
    check({tag, "_cnt"}, {dec10, dec1}, bcd);
    check({tag, "_dclk"}, {7'd0, dec_clk}, {7'd0, pulse});
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  int model;

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    pulse_cnt = 0;
    reset_p = 1'b0; load_enable = 1'b0; clk_time = 1'b0;
    set_value1 = 4'd0; set_value10 = 4'd0;
    @(negedge clk);

    // 1: reset then hold
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    expect_cnt("reset", 8'h00, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    expect_cnt("hold00", 8'h00, 1'b0);

    // 2: load 35, then 40 ticks 1000 ns apart
    cycle(1'b0, 1'b1, 1'b0, 4'd3, 4'd5);
    expect_cnt("load35", 8'h35, 1'b0);
    pulse_cnt = 0;
    model = 35;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
      model = (model == 0) ? 59 : model - 1;
      expect_cnt($sformatf("tick%0d", i), to_bcd(model), (i == 36));
      repeat (99) cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      if (i == 36) expect_cnt("after_wrap", 8'h59, 1'b0);
    end
    expect_cnt("run_end", 8'h55, 1'b0);
    check("pulse_count", 8'(pulse_cnt), 8'd1);

    // 3: wrap directly from reset
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_cnt("wrap59", 8'h59, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    expect_cnt("wrap_clear", 8'h59, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_cnt("tick58", 8'h58, 1'b0);

    // 4: load beats tick; clamping
    cycle(1'b0, 1'b1, 1'b1, 4'd2, 4'd0);
    expect_cnt("load_vs_tick", 8'h20, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 4'd7, 4'd12);
    expect_cnt("clamp_both", 8'h59, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 4'd3, 4'd15);
    expect_cnt("clamp_ones", 8'h39, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 4'd9, 4'd4);
    expect_cnt("clamp_tens", 8'h54, 1'b0);

    // load from 00 with a tick must not pulse dec_clk
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    cycle(1'b0, 1'b1, 1'b1, 4'd4, 4'd2);
    expect_cnt("load_at_00", 8'h42, 1'b0);

    // 5: ones borrow into tens, then reset beats tick
    cycle(1'b0, 1'b1, 1'b0, 4'd1, 4'd0);
    expect_cnt("load10", 8'h10, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_cnt("borrow09", 8'h09, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_cnt("tick08", 8'h08, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_cnt("reset_vs_tick", 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 4'd3, 4'd3);
    expect_cnt("reset_vs_load", 8'h00, 1'b0);

    // held tick: 3 consecutive high cycles give 3 decrements
    cycle(1'b0, 1'b1, 1'b0, 4'd2, 4'd1);
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_cnt("held_tick", 8'h18, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
